controlador_juego: RTL and testbench

//  Main sequencer for the 4x4 2048 board datapath. Drives the 3-bit move/generate selector and the board-register load enable.

---
 rtl/controlador_juego.sv | 164 ++++++++++++++++
 tb/tb_controlador_juego.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_juego.sv
// Main sequencer for the 4x4 2048 board: turns button edges into single moves,
// spawns one tile after each valid move, then checks for a win or a loss.
module controlador_juego #(
    parameter int                    ANCHO_MOV  = 16,
    parameter int                    ANCHO_LFSR = 8,
    parameter logic [ANCHO_LFSR-1:0] SEMILLA    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_izq,
    input  logic                  btn_der,
    input  logic                  btn_arr,
    input  logic                  btn_aba,
    input  logic                  btn_reiniciar,
    input  logic                  tablero_cambio,
    input  logic                  hay_2048,
    input  logic                  hay_movimiento,
    output logic [2:0]            selector,
    output logic                  cargar_tablero,
    output logic [ANCHO_LFSR-1:0] aleatorio,
    output logic                  gano,
    output logic                  perdio,
    output logic [ANCHO_MOV-1:0]  movimientos,
    output logic [3:0]            estado
);

    typedef enum logic [3:0] {
        LIMPIAR   = 4'd0,
        GEN_INI1  = 4'd1,
        GEN_INI2  = 4'd2,
        ESPERA    = 4'd3,
        MOVER     = 4'd4,
        GENERAR   = 4'd5,
        VERIFICAR = 4'd6,
        GANO      = 4'd7,
        PERDIO    = 4'd8
    } estado_t;

    localparam logic [2:0] SEL_LIMPIAR = 3'b000;
    localparam logic [2:0] SEL_IZQ     = 3'b001;
    localparam logic [2:0] SEL_DER     = 3'b010;
    localparam logic [2:0] SEL_ARR     = 3'b011;
    localparam logic [2:0] SEL_ABA     = 3'b100;
    localparam logic [2:0] SEL_GENERAR = 3'b101;
    localparam logic [2:0] SEL_ESPERA  = 3'b111;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [ANCHO_LFSR-1:0] SEMILLA_EF =
        (SEMILLA == '0) ? ANCHO_LFSR'(1) : SEMILLA;

    localparam logic [ANCHO_MOV-1:0] MOV_MAX = {ANCHO_MOV{1'b1}};

    estado_t               estado_q, estado_d;
    logic [4:0]            btn_q, btn_d;
    logic [4:0]            flanco;
    logic [2:0]            dir_q, dir_d;
    logic [ANCHO_MOV-1:0]  mov_q, mov_d;
    logic [ANCHO_LFSR-1:0] lfsr_q, lfsr_d;

    // Bit order: {reiniciar, aba, arr, der, izq}.
    assign btn_d  = {btn_reiniciar, btn_aba, btn_arr, btn_der, btn_izq};
    assign flanco = btn_d & ~btn_q;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        estado_d       = estado_q;
        dir_d          = dir_q;
        mov_d          = mov_q;
        selector       = SEL_ESPERA;
        cargar_tablero = 1'b0;

        case (estado_q)
            LIMPIAR: begin
                selector       = SEL_LIMPIAR;
                cargar_tablero = 1'b1;
                estado_d       = GEN_INI1;
            end
            GEN_INI1: begin
                selector       = SEL_GENERAR;
                cargar_tablero = 1'b1;
                estado_d       = GEN_INI2;
            end
            GEN_INI2: begin
                selector       = SEL_GENERAR;
                cargar_tablero = 1'b1;
                estado_d       = ESPERA;
            end
            ESPERA: begin
                if (flanco[0]) begin
                    dir_d    = SEL_IZQ;
                    estado_d = MOVER;
                end else if (flanco[1]) begin
                    dir_d    = SEL_DER;
                    estado_d = MOVER;
                end else if (flanco[2]) begin
                    dir_d    = SEL_ARR;
                    estado_d = MOVER;
                end else if (flanco[3]) begin
                    dir_d    = SEL_ABA;
                    estado_d = MOVER;
                end
            end
            MOVER: begin
                // A move that leaves the board unchanged is not a move.
                selector       = dir_q;
                cargar_tablero = tablero_cambio;
                if (tablero_cambio) begin
                    mov_d    = (mov_q == MOV_MAX) ? mov_q : mov_q + ANCHO_MOV'(1);
                    estado_d = GENERAR;
                end else begin
                    estado_d = ESPERA;
                end
            end
            GENERAR: begin
                selector       = SEL_GENERAR;
                cargar_tablero = 1'b1;
                estado_d       = VERIFICAR;
            end
            VERIFICAR: begin
                if (hay_2048) begin
                    estado_d = GANO;
                end else if (!hay_movimiento) begin
                    estado_d = PERDIO;
                end else begin
                    estado_d = ESPERA;
                end
            end
            GANO:    estado_d = GANO;
            PERDIO:  estado_d = PERDIO;
            default: estado_d = LIMPIAR;
        endcase

        if (flanco[4]) begin
            estado_d = LIMPIAR;
        end
        if (estado_d == LIMPIAR) begin
            mov_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= LIMPIAR;
            btn_q    <= '0;
            dir_q    <= SEL_ESPERA;
            mov_q    <= '0;
            lfsr_q   <= SEMILLA_EF;
        end else begin
            estado_q <= estado_d;
            btn_q    <= btn_d;
            dir_q    <= dir_d;
            mov_q    <= mov_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign aleatorio   = lfsr_q;
    assign gano        = (estado_q == GANO);
    assign perdio      = (estado_q == PERDIO);
    assign movimientos = mov_q;
    assign estado      = estado_q;

endmodule

// File: tb/tb_controlador_juego.sv
// Directed bench for controlador_juego: start-up sequence, moves, priority,
// win/lose, restart, reset mid-move, LFSR period and counter saturation.
module tb_controlador_juego;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_izq = 1'b0, btn_der = 1'b0, btn_arr = 1'b0, btn_aba = 1'b0;
    logic        btn_reiniciar = 1'b0;
    logic        tablero_cambio = 1'b0, hay_2048 = 1'b0, hay_movimiento = 1'b1;

    logic [2:0]  selector;
    logic        cargar_tablero, gano, perdio;
    logic [7:0]  aleatorio;
    logic [15:0] movimientos;
    logic [3:0]  estado;

    logic [2:0]  selector_b;
    logic        cargar_tablero_b, gano_b, perdio_b;
    logic [7:0]  aleatorio_b;
    logic [1:0]  movimientos_b;
    logic [3:0]  estado_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    controlador_juego dut (
        .clk(clk), .rst(rst),
        .btn_izq(btn_izq), .btn_der(btn_der), .btn_arr(btn_arr), .btn_aba(btn_aba),
        .btn_reiniciar(btn_reiniciar),
        .tablero_cambio(tablero_cambio), .hay_2048(hay_2048), .hay_movimiento(hay_movimiento),
        .selector(selector), .cargar_tablero(cargar_tablero), .aleatorio(aleatorio),
        .gano(gano), .perdio(perdio), .movimientos(movimientos), .estado(estado)
    );

    // Zero seed and a 2-bit move counter to reach seed replacement and saturation.
    controlador_juego #(.ANCHO_MOV(2), .ANCHO_LFSR(8), .SEMILLA(8'h00)) dut_b (
        .clk(clk), .rst(rst),
        .btn_izq(btn_izq), .btn_der(btn_der), .btn_arr(btn_arr), .btn_aba(btn_aba),
        .btn_reiniciar(btn_reiniciar),
        .tablero_cambio(tablero_cambio), .hay_2048(hay_2048), .hay_movimiento(hay_movimiento),
        .selector(selector_b), .cargar_tablero(cargar_tablero_b), .aleatorio(aleatorio_b),
        .gano(gano_b), .perdio(perdio_b), .movimientos(movimientos_b), .estado(estado_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({estado, selector, cargar_tablero} !== {4'd0, 3'b000, 1'b1}) begin
            bad++;
            $display("FAIL reset_fsm got=%h/%b/%b want=0/000/1", estado, selector, cargar_tablero);
        end
        total++;
        if ({gano, perdio, movimientos} !== {1'b0, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL reset_out got gano=%b perdio=%b mov=%0d want 0/0/0", gano, perdio, movimientos);
        end
        total++;
        if (aleatorio !== 8'hA5) begin
            bad++;
            $display("FAIL reset_lfsr got=%h want=a5", aleatorio);
        end
        total++;
        if (aleatorio_b !== 8'h01) begin
            bad++;
            $display("FAIL reset_seed0 got=%h want=01", aleatorio_b);
        end
        rst = 1'b0;
        step();
        total++;
        if ({estado, selector, cargar_tablero} !== {4'd1, 3'b101, 1'b1}) begin
            bad++;
            $display("FAIL init_gen1 got=%h/%b/%b want=1/101/1", estado, selector, cargar_tablero);
        end
        total++;
        if (aleatorio !== 8'h4A) begin
            bad++;
            $display("FAIL lfsr_second got=%h want=4a", aleatorio);
        end
        step();
        total++;
        if ({estado, selector, cargar_tablero} !== {4'd2, 3'b101, 1'b1}) begin
            bad++;
            $display("FAIL init_gen2 got=%h/%b/%b want=2/101/1", estado, selector, cargar_tablero);
        end
        step();
        total++;
        if ({estado, selector, cargar_tablero, movimientos} !== {4'd3, 3'b111, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL init_espera got=%h/%b/%b mov=%0d want=3/111/0 mov=0",
                     estado, selector, cargar_tablero, movimientos);
        end
    endtask

    task automatic test_lfsr_period();
        int vuelta;
        logic cero;
        vuelta = 0;
        cero   = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (aleatorio == 8'h00) cero = 1'b1;
            if (aleatorio == 8'hA5 && vuelta == 0) vuelta = i;
        end
        total++;
        if (cero !== 1'b0) begin
            bad++;
            $display("FAIL lfsr_zero got a zero value want none");
        end
        total++;
        if (vuelta != 255) begin
            bad++;
            $display("FAIL lfsr_period got=%0d want=255", vuelta);
        end
        total++;
        if (estado !== 4'd3) begin
            bad++;
            $display("FAIL lfsr_idle_state got=%0d want=3", estado);
        end
    endtask

    task automatic test_move_held();
        tablero_cambio = 1'b1;
        hay_movimiento = 1'b1;
        hay_2048       = 1'b0;
        btn_izq        = 1'b1;
        step();
        total++;
        if ({estado, selector, cargar_tablero} !== {4'd4, 3'b001, 1'b1}) begin
            bad++;
            $display("FAIL held_mover got=%h/%b/%b want=4/001/1", estado, selector, cargar_tablero);
        end
        step();
        total++;
        if ({estado, selector, cargar_tablero, movimientos} !== {4'd5, 3'b101, 1'b1, 16'd1}) begin
            bad++;
            $display("FAIL held_generar got=%h/%b/%b mov=%0d want=5/101/1 mov=1",
                     estado, selector, cargar_tablero, movimientos);
        end
        step();
        total++;
        if ({estado, selector, cargar_tablero} !== {4'd6, 3'b111, 1'b0}) begin
            bad++;
            $display("FAIL held_verificar got=%h/%b/%b want=6/111/0", estado, selector, cargar_tablero);
        end
        for (int i = 0; i < 7; i++) step();
        total++;
        if ({estado, movimientos} !== {4'd3, 16'd1}) begin
            bad++;
            $display("FAIL held_single got=%0d mov=%0d want=3 mov=1", estado, movimientos);
        end
        btn_izq = 1'b0;
        step();
    endtask

    task automatic test_no_change();
        tablero_cambio = 1'b0;
        btn_der        = 1'b1;
        step();
        total++;
        if ({estado, selector, cargar_tablero} !== {4'd4, 3'b010, 1'b0}) begin
            bad++;
            $display("FAIL nochg_mover got=%h/%b/%b want=4/010/0", estado, selector, cargar_tablero);
        end
        step();
        total++;
        if ({estado, movimientos} !== {4'd3, 16'd1}) begin
            bad++;
            $display("FAIL nochg_back got=%0d mov=%0d want=3 mov=1", estado, movimientos);
        end
        btn_der = 1'b0;
        step();
    endtask

    task automatic test_priority_and_discard();
        tablero_cambio = 1'b1;
        btn_arr        = 1'b1;
        btn_aba        = 1'b1;
        step();
        total++;
        if ({estado, selector} !== {4'd4, 3'b011}) begin
            bad++;
            $display("FAIL prio_arr got=%h/%b want=4/011", estado, selector);
        end
        btn_arr = 1'b0;
        btn_aba = 1'b0;
        step();
        btn_izq = 1'b1;
        step();
        step();
        step();
        total++;
        if ({estado, movimientos} !== {4'd3, 16'd2}) begin
            bad++;
            $display("FAIL discard_edge got=%0d mov=%0d want=3 mov=2", estado, movimientos);
        end
        btn_izq = 1'b0;
        step();
    endtask

    task automatic test_win_restart();
        hay_2048 = 1'b1;
        btn_der  = 1'b1;
        step();
        step();
        step();
        step();
        total++;
        if ({estado, gano, perdio, movimientos} !== {4'd7, 1'b1, 1'b0, 16'd3}) begin
            bad++;
            $display("FAIL win got=%0d g=%b p=%b mov=%0d want=7 g=1 p=0 mov=3",
                     estado, gano, perdio, movimientos);
        end
        btn_der = 1'b0;
        btn_izq = 1'b1;
        step();
        total++;
        if ({estado, selector, cargar_tablero} !== {4'd7, 3'b111, 1'b0}) begin
            bad++;
            $display("FAIL win_ignore got=%h/%b/%b want=7/111/0", estado, selector, cargar_tablero);
        end
        btn_izq       = 1'b0;
        btn_reiniciar = 1'b1;
        hay_2048      = 1'b0;
        step();
        total++;
        if ({estado, selector, cargar_tablero, gano, movimientos} !== {4'd0, 3'b000, 1'b1, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL restart got=%h/%b/%b g=%b mov=%0d want=0/000/1 g=0 mov=0",
                     estado, selector, cargar_tablero, gano, movimientos);
        end
        btn_reiniciar = 1'b0;
        step();
        step();
        step();
        total++;
        if (estado !== 4'd3) begin
            bad++;
            $display("FAIL restart_espera got=%0d want=3", estado);
        end
    endtask

    task automatic test_lose();
        hay_movimiento = 1'b0;
        tablero_cambio = 1'b1;
        btn_aba        = 1'b1;
        step();
        total++;
        if ({estado, selector, cargar_tablero} !== {4'd4, 3'b100, 1'b1}) begin
            bad++;
            $display("FAIL lose_mover got=%h/%b/%b want=4/100/1", estado, selector, cargar_tablero);
        end
        step();
        step();
        step();
        total++;
        if ({estado, gano, perdio, movimientos} !== {4'd8, 1'b0, 1'b1, 16'd1}) begin
            bad++;
            $display("FAIL lose got=%0d g=%b p=%b mov=%0d want=8 g=0 p=1 mov=1",
                     estado, gano, perdio, movimientos);
        end
        btn_aba = 1'b0;
        btn_arr = 1'b1;
        step();
        total++;
        if ({estado, perdio} !== {4'd8, 1'b1}) begin
            bad++;
            $display("FAIL lose_ignore got=%0d p=%b want=8 p=1", estado, perdio);
        end
        btn_arr = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_move();
        btn_reiniciar  = 1'b1;
        step();
        btn_reiniciar  = 1'b0;
        hay_movimiento = 1'b1;
        step();
        step();
        step();
        btn_izq = 1'b1;
        step();
        total++;
        if (estado !== 4'd4) begin
            bad++;
            $display("FAIL midmove_enter got=%0d want=4", estado);
        end
        rst = 1'b1;
        step();
        total++;
        if ({estado, selector, cargar_tablero, movimientos} !== {4'd0, 3'b000, 1'b1, 16'd0}) begin
            bad++;
            $display("FAIL midmove_abort got=%h/%b/%b mov=%0d want=0/000/1 mov=0",
                     estado, selector, cargar_tablero, movimientos);
        end
        btn_izq = 1'b0;
        rst     = 1'b0;
        step();
        step();
        step();
        total++;
        if (estado !== 4'd3) begin
            bad++;
            $display("FAIL midmove_recover got=%0d want=3", estado);
        end
    endtask

    task automatic test_back_to_back();
        tablero_cambio = 1'b1;
        hay_movimiento = 1'b1;
        for (int k = 0; k < 5; k++) begin
            btn_izq = 1'b1;
            step();
            step();
            step();
            step();
            btn_izq = 1'b0;
            step();
        end
        total++;
        if (movimientos !== 16'd5) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=5", movimientos);
        end
        total++;
        if (movimientos_b !== 2'd3) begin
            bad++;
            $display("FAIL b2b_saturate got=%0d want=3", movimientos_b);
        end
    endtask

    initial begin
        test_reset();
        test_lfsr_period();
        test_move_held();
        test_no_change();
        test_priority_and_discard();
        test_win_restart();
        test_lose();
        test_reset_mid_move();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
